// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait freezes
// with a sticky timeout, plus saturating stall/flush event counters.
module pipe_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_rd_i,
  input  logic [4:0]  IFID_rs1_i,
  input  logic [4:0]  IFID_rs2_i,
  input  logic        Branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic        IFIDFlush_o,
  output logic        Freeze_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic        mem_timeout_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam logic [7:0]  TIMEOUT_LAST = 8'd254;
  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;
  logic        mem_timeout_reg;

  logic mem_busy;
  logic load_use;
  logic busy_wait;
  logic timeout_hit;

  assign mem_busy    = mem_req_i & ~mem_ack_i;
  assign load_use    = IDEX_MemRead_i & (IDEX_rd_i != 5'd0) &
                       ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));
  assign busy_wait   = (state_reg == MEMWAIT) & mem_busy;
  // wait_cnt lags the busy run by one cycle, so 254 marks the 256th busy cycle
  assign timeout_hit = busy_wait & (wait_cnt_reg == TIMEOUT_LAST);

  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    IFIDFlush_o = 1'b0;
    Freeze_o    = 1'b0;
    if (state_reg == ERROR || mem_busy) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      Freeze_o    = 1'b1;
    end else if (load_use) begin
      // a coincident branch is dropped here and re-resolved after the bubble
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end else if (Branch_taken_i) begin
      IFIDFlush_o = 1'b1;
    end
  end

  always_comb begin
    state_next = RUN;
    if (state_reg == ERROR || timeout_hit) begin
      state_next = ERROR;
    end else if (mem_busy) begin
      state_next = MEMWAIT;
    end else if (load_use) begin
      state_next = LDSTALL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      stall_cnt_reg   <= 32'd0;
      flush_cnt_reg   <= 32'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= busy_wait ? wait_cnt_reg + 8'd1 : 8'd0;
      if (timeout_hit) begin
        mem_timeout_reg <= 1'b1;
      end
      if (!PCWrite_o && stall_cnt_reg != CNT_MAX) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (IFIDFlush_o && flush_cnt_reg != CNT_MAX) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign state_o       = state_reg;
  assign stall_cnt_o   = stall_cnt_reg;
  assign flush_cnt_o   = flush_cnt_reg;
  assign mem_timeout_o = mem_timeout_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control outputs are compared as the
// packed vector {PCWrite, IFIDWrite, NoOp, IFIDFlush, Freeze}.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        IDEX_MemRead_i = 1'b0;
  logic [4:0]  IDEX_rd_i = 5'd0;
  logic [4:0]  IFID_rs1_i = 5'd0;
  logic [4:0]  IFID_rs2_i = 5'd0;
  logic        Branch_taken_i = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic        PCWrite_o, IFIDWrite_o, NoOp_o, IFIDFlush_o, Freeze_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic        mem_timeout_o;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_BUB   = 5'b00100;
  localparam logic [4:0] C_FLUSH = 5'b11010;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  wire [4:0] ctl = {PCWrite_o, IFIDWrite_o, NoOp_o, IFIDFlush_o, Freeze_o};

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
    .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
    .Branch_taken_i(Branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .NoOp_o(NoOp_o),
    .IFIDFlush_o(IFIDFlush_o), .Freeze_o(Freeze_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .mem_timeout_o(mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic req, input logic ack);
    IDEX_MemRead_i = mr; IDEX_rd_i = rd; IFID_rs1_i = rs1; IFID_rs2_i = rs2;
    Branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state_o); end
    tests++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0 || mem_timeout_o !== 1'b0) begin
      fails++; $display("FAIL reset_cnt got stall=%0d flush=%0d to=%0b want 0/0/0", stall_cnt_o, flush_cnt_o, mem_timeout_o); end
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, C_RUN); end
    step(); step();
    rst_i = 1'b0;
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd0) begin
      fails++; $display("FAIL post_reset got state=%0d stall=%0d want 0/0", state_o, stall_cnt_o); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use();
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    tests++; if (ctl !== C_BUB) begin fails++; $display("FAIL lu_rs1_ctl got %b want %b", ctl, C_BUB); end
    step();
    tests++; if (state_o !== 2'd1 || stall_cnt_o !== 32'd1) begin
      fails++; $display("FAIL lu_rs1_next got state=%0d stall=%0d want 1/1", state_o, stall_cnt_o); end
    drive(1, 5'd7, 5'd3, 5'd7, 0, 0, 0);
    tests++; if (ctl !== C_BUB) begin fails++; $display("FAIL lu_rs2_ctl got %b want %b", ctl, C_BUB); end
    step();
    tests++; if (state_o !== 2'd1 || stall_cnt_o !== 32'd2) begin
      fails++; $display("FAIL lu_rs2_next got state=%0d stall=%0d want 1/2", state_o, stall_cnt_o); end
    drive(0, 5'd7, 5'd7, 5'd7, 0, 0, 0);
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL no_memread_ctl got %b want %b", ctl, C_RUN); end
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd2) begin
      fails++; $display("FAIL no_memread_next got state=%0d stall=%0d want 0/2", state_o, stall_cnt_o); end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_x0_load();
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL x0_ctl got %b want %b", ctl, C_RUN); end
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd2) begin
      fails++; $display("FAIL x0_next got state=%0d stall=%0d want 0/2", state_o, stall_cnt_o); end
    $display("[TB] test_x0_load done");
  endtask

  task automatic test_branch_load_use();
    drive(1, 5'd9, 5'd9, 5'd1, 1, 0, 0);
    tests++; if (ctl !== C_BUB) begin fails++; $display("FAIL br_lu_ctl got %b want %b", ctl, C_BUB); end
    step();
    tests++; if (state_o !== 2'd1 || flush_cnt_o !== 32'd0 || stall_cnt_o !== 32'd3) begin
      fails++; $display("FAIL br_lu_next got state=%0d flush=%0d stall=%0d want 1/0/3", state_o, flush_cnt_o, stall_cnt_o); end
    drive(0, 5'd9, 5'd9, 5'd1, 1, 0, 0);
    tests++; if (ctl !== C_FLUSH) begin fails++; $display("FAIL br_ctl got %b want %b", ctl, C_FLUSH); end
    step();
    tests++; if (state_o !== 2'd0 || flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd3) begin
      fails++; $display("FAIL br_next got state=%0d flush=%0d stall=%0d want 0/1/3", state_o, flush_cnt_o, stall_cnt_o); end
    $display("[TB] test_branch_load_use done");
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      // middle cycle also raises load-use and branch: mem_busy must win
      if (i == 1) drive(1, 5'd4, 5'd4, 5'd0, 1, 1, 0);
      else        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL memwait_ctl[%0d] got %b want %b", i, ctl, C_FRZ); end
      step();
      tests++; if (state_o !== 2'd2) begin fails++; $display("FAIL memwait_state[%0d] got %0d want 2", i, state_o); end
    end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL mem_ack_ctl got %b want %b", ctl, C_RUN); end
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd6 || flush_cnt_o !== 32'd1) begin
      fails++; $display("FAIL mem_ack_next got state=%0d stall=%0d flush=%0d want 0/6/1", state_o, stall_cnt_o, flush_cnt_o); end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL lone_ack_ctl got %b want %b", ctl, C_RUN); end
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd6) begin
      fails++; $display("FAIL lone_ack_next got state=%0d stall=%0d want 0/6", state_o, stall_cnt_o); end
    $display("[TB] test_mem_wait done");
  endtask

  task automatic test_timeout();
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 255; i++) step();
    tests++; if (state_o !== 2'd2 || mem_timeout_o !== 1'b0) begin
      fails++; $display("FAIL timeout_255 got state=%0d to=%0b want 2/0", state_o, mem_timeout_o); end
    step();
    tests++; if (state_o !== 2'd3 || mem_timeout_o !== 1'b1 || stall_cnt_o !== 32'd262) begin
      fails++; $display("FAIL timeout_256 got state=%0d to=%0b stall=%0d want 3/1/262", state_o, mem_timeout_o, stall_cnt_o); end
    drive(1, 5'd6, 5'd6, 5'd0, 1, 1, 1);
    tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL error_ctl got %b want %b", ctl, C_FRZ); end
    step();
    tests++; if (state_o !== 2'd3 || mem_timeout_o !== 1'b1 || stall_cnt_o !== 32'd263 || flush_cnt_o !== 32'd1) begin
      fails++; $display("FAIL error_hold got state=%0d to=%0b stall=%0d flush=%0d want 3/1/263/1", state_o, mem_timeout_o, stall_cnt_o, flush_cnt_o); end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    tests++; if (state_o !== 2'd0 || mem_timeout_o !== 1'b0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      fails++; $display("FAIL error_reset got state=%0d to=%0b stall=%0d flush=%0d want 0/0/0/0", state_o, mem_timeout_o, stall_cnt_o, flush_cnt_o); end
    tests++; if (ctl !== C_RUN) begin fails++; $display("FAIL error_reset_ctl got %b want %b", ctl, C_RUN); end
    rst_i = 1'b0;
    step();
    tests++; if (state_o !== 2'd0 || ctl !== C_RUN) begin
      fails++; $display("FAIL after_error_reset got state=%0d ctl=%b want 0/%b", state_o, ctl, C_RUN); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_async_reset_memwait();
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    step(); step();
    tests++; if (state_o !== 2'd2 || stall_cnt_o !== 32'd2) begin
      fails++; $display("FAIL pre_async got state=%0d stall=%0d want 2/2", state_o, stall_cnt_o); end
    rst_i = 1'b1;
    #1;
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      fails++; $display("FAIL async_reset got state=%0d stall=%0d flush=%0d want 0/0/0", state_o, stall_cnt_o, flush_cnt_o); end
    tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL async_reset_ctl got %b want %b", ctl, C_FRZ); end
    rst_i = 1'b0;
    step();
    tests++; if (state_o !== 2'd2 || stall_cnt_o !== 32'd1) begin
      fails++; $display("FAIL async_release got state=%0d stall=%0d want 2/1", state_o, stall_cnt_o); end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step();
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL async_idle got state=%0d want 0", state_o); end
    $display("[TB] test_async_reset_memwait done");
  endtask

  task automatic test_back_to_back();
    drive(1, 5'd10, 5'd10, 5'd0, 0, 0, 0);
    step();
    drive(1, 5'd11, 5'd0, 5'd11, 0, 0, 0);
    tests++; if (ctl !== C_BUB) begin fails++; $display("FAIL b2b_ctl got %b want %b", ctl, C_BUB); end
    step();
    drive(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    step();
    tests++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd3 || flush_cnt_o !== 32'd1) begin
      fails++; $display("FAIL b2b_end got state=%0d stall=%0d flush=%0d want 0/3/1", state_o, stall_cnt_o, flush_cnt_o); end
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_async_reset_memwait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
